// File: rtl/occupancy_counter.sv
// ---------------------------------------------------------------------------
// occupancy_counter
//
// Room head-count across NUM_DOORS doorways. Each doorway has an outer (A)
// and an inner (B) beam-break sensor. A per-door direction FSM turns a full
// A -> AB -> B -> clear traversal into an entry (B-first mirror: an exit),
// drops back-outs, and aborts any door that stays busy for TIMEOUT_CYC
// cycles. A shared saturating counter keeps the occupancy.
//
// Optional build macro: OCC_DEBOUNCE_EN
//   When defined, every synchronised sensor bit must hold a new value for
//   DEB_CYC consecutive cycles before the FSM sees it.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   ir_a         in   [NUM_DOORS] outer beam per door, 1 = broken
//   ir_b         in   [NUM_DOORS] inner beam per door, 1 = broken
//   clear        in   synchronous: occupancy and err to 0 (FSMs untouched)
//   entry_pulse  out  [NUM_DOORS] one-cycle pulse per completed entry
//   exit_pulse   out  [NUM_DOORS] one-cycle pulse per completed exit
//   occupancy    out  [COUNT_W]   current head count
//   occupied     out  occupancy != 0
//   full         out  occupancy == MAX_OCC
//   err          out  sticky: clamped update or door timeout
// ---------------------------------------------------------------------------
module occupancy_counter #(
    parameter int NUM_DOORS   = 4,
    parameter int COUNT_W     = 8,
    parameter int MAX_OCC     = 200,
    parameter int TIMEOUT_CYC = 50000,
    parameter int DEB_CYC     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_DOORS-1:0] ir_a,
    input  logic [NUM_DOORS-1:0] ir_b,
    input  logic                 clear,
    output logic [NUM_DOORS-1:0] entry_pulse,
    output logic [NUM_DOORS-1:0] exit_pulse,
    output logic [COUNT_W-1:0]   occupancy,
    output logic                 occupied,
    output logic                 full,
    output logic                 err
);

    localparam int SUM_W = COUNT_W + 4;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_OCC);
    localparam bit CFG_OK = (NUM_DOORS >= 1) && (NUM_DOORS <= 8) &&
                            (MAX_OCC < (2 ** COUNT_W)) && (TIMEOUT_CYC >= 2) &&
                            (DEB_CYC >= 1);

    if (!CFG_OK) begin : g_cfg_check
        $error("occupancy_counter: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3, WAIT_CLR
    } door_state_t;

    // Number of set bits, as a signed value ready for the occupancy sum.
    function automatic logic signed [SUM_W-1:0] pop_s(input logic [NUM_DOORS-1:0] v);
        logic signed [SUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_DOORS; i++) begin
            n = n + $signed({{(SUM_W-1){1'b0}}, v[i]});
        end
        return n;
    endfunction

    function automatic logic out_of_range(input logic signed [SUM_W-1:0] v);
        return v[SUM_W-1] || (v > MAX_S);
    endfunction

    function automatic logic [COUNT_W-1:0] sat_occ(input logic signed [SUM_W-1:0] v);
        if (v[SUM_W-1]) begin
            return '0;
        end else if (v > MAX_S) begin
            return COUNT_W'(MAX_OCC);
        end else begin
            return v[COUNT_W-1:0];
        end
    endfunction

    // ---- stage p0/p1: two-flop synchronisers ----
    logic [NUM_DOORS-1:0] a_p0, a_p1, b_p0, b_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_p0 <= '0;
            a_p1 <= '0;
            b_p0 <= '0;
            b_p1 <= '0;
        end else begin
            a_p0 <= ir_a;
            a_p1 <= a_p0;
            b_p0 <= ir_b;
            b_p1 <= b_p0;
        end
    end

    logic [NUM_DOORS-1:0] a_in, b_in;

`ifdef OCC_DEBOUNCE_EN
    // ---- optional debounce stage ----
    localparam int DEB_W = $clog2(DEB_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    logic [2*NUM_DOORS-1:0] deb_raw, deb_q;
    logic [DEB_W-1:0]       deb_cnt [2*NUM_DOORS];

    assign deb_raw = {b_p1, a_p1};

    // The counter only runs while the raw bit disagrees with the filtered
    // bit, so any return to the old value restarts the stability window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_q <= '0;
            for (int i = 0; i < 2*NUM_DOORS; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2*NUM_DOORS; i++) begin
                if (deb_raw[i] == deb_q[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_q[i]   <= deb_raw[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign a_in = deb_q[NUM_DOORS-1:0];
    assign b_in = deb_q[2*NUM_DOORS-1:NUM_DOORS];
`else
    assign a_in = a_p1;
    assign b_in = b_p1;
`endif

    // ---- stage p2: per-door direction FSMs ----
    logic [NUM_DOORS-1:0] ent_done_p2, ext_done_p2, tmo_p2;

    for (genvar d = 0; d < NUM_DOORS; d++) begin : g_door
        door_state_t      state;
        logic [TMR_W-1:0] timer;
        logic             a, b;
        logic             ent_done, ext_done, tmo;

        assign a = a_in[d];
        assign b = b_in[d];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state    <= IDLE;
                timer    <= '0;
                ent_done <= 1'b0;
                ext_done <= 1'b0;
                tmo      <= 1'b0;
            end else begin
                ent_done <= 1'b0;
                ext_done <= 1'b0;
                tmo      <= 1'b0;
                // Timeout overrides every normal transition; the timer
                // restarts so a stuck WAIT_CLR keeps re-flagging err.
                if (state != IDLE && timer == TMR_LAST) begin
                    state <= WAIT_CLR;
                    timer <= '0;
                    tmo   <= 1'b1;
                end else begin
                    timer <= (state == IDLE) ? '0 : timer + 1'b1;
                    case (state)
                        IDLE: begin
                            if (a && !b)      state <= ENT1;
                            else if (!a && b) state <= EXT1;
                            else if (a && b)  state <= WAIT_CLR;
                        end
                        ENT1: begin
                            if (a && b)        state <= ENT2;
                            else if (!a && !b) state <= IDLE;
                        end
                        ENT2: begin
                            if (!a && b)      state <= ENT3;
                            else if (a && !b) state <= ENT1;
                        end
                        ENT3: begin
                            if (!a && !b) begin
                                state    <= IDLE;
                                ent_done <= 1'b1;
                            end else if (a && b) begin
                                state <= ENT2;
                            end
                        end
                        EXT1: begin
                            if (a && b)        state <= EXT2;
                            else if (!a && !b) state <= IDLE;
                        end
                        EXT2: begin
                            if (a && !b)      state <= EXT3;
                            else if (!a && b) state <= EXT1;
                        end
                        EXT3: begin
                            if (!a && !b) begin
                                state    <= IDLE;
                                ext_done <= 1'b1;
                            end else if (a && b) begin
                                state <= EXT2;
                            end
                        end
                        WAIT_CLR: begin
                            if (!a && !b) state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end

        assign ent_done_p2[d] = ent_done;
        assign ext_done_p2[d] = ext_done;
        assign tmo_p2[d]      = tmo;
    end

    // ---- stage p3: pulse registers ----
    logic tmo_p3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_pulse <= '0;
            exit_pulse  <= '0;
            tmo_p3      <= 1'b0;
        end else begin
            entry_pulse <= ent_done_p2;
            exit_pulse  <= ext_done_p2;
            tmo_p3      <= |tmo_p2;
        end
    end

    // ---- stage p4: saturating occupancy counter ----
    logic signed [SUM_W-1:0] occ_sum;

    assign occ_sum = $signed({4'b0000, occupancy}) + pop_s(entry_pulse) - pop_s(exit_pulse);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy <= '0;
            err       <= 1'b0;
        end else if (clear) begin
            occupancy <= '0;
            err       <= 1'b0;
        end else begin
            occupancy <= sat_occ(occ_sum);
            if (out_of_range(occ_sum) || tmo_p3) err <= 1'b1;
        end
    end

    assign occupied = (occupancy != '0);
    assign full     = (occupancy == COUNT_W'(MAX_OCC));

endmodule
